// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake bundle for the seven-segment scan controller.
// The master side (system or bench) offers a packed BCD value on load_data.
// It raises load_req to offer it. The slave (the controller) answers with a one-cycle load_ack.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_req;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    load_ack;

    modport master (
        output load_req,
        output load_data,
        input  load_ack
    );

    modport slave (
        input  load_req,
        input  load_data,
        output load_ack
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
// Each digit slot lasts REFRESH_DIV cycles and starts with BLANK_CYCLES of all-off
// enables to stop ghosting. digit_bcd feeds an external BCD-to-segment decoder.
// A loaded value waits in a pending register. It becomes the displayed value only at a
// frame wrap or while the display is off, so a frame never mixes two values.
// Every output is registered, so the outputs show the state entered on the last edge.
// frame_done is therefore high during the first blank cycle of the new frame.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      lzb,
    seven_seg_scan_ctrl_if.slave      load_bus,
    output logic [3:0]                digit_bcd,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [VW-1:0]   active;
    logic [VW-1:0]   pending;
    logic            pending_valid;

    logic            frame_wrap;
    logic            commit;
    logic [VW-1:0]   active_nx;
    logic [IW-1:0]   idx_nx;
    logic [NUM_DIGITS-1:0] show_mask;

    // Extract the BCD nibble of digit i from a packed value.
    function automatic logic [3:0] nibble(input logic [VW-1:0] value, input int i);
        return value[4*i +: 4];
    endfunction

    // A digit is lit unless it has no decoder pattern (>9), or it is a blanked leading zero.
    // Digit 0 is never blanked as a leading zero, so a zero value still shows "0".
    function automatic logic digit_visible(input logic [VW-1:0] value, input int i,
                                           input logic blank_lz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= i && value[4*j +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        if (value[4*i +: 4] > 4'd9) begin
            return 1'b0;
        end
        return !(blank_lz && i != 0 && upper_zero);
    endfunction

    // Work out frame wrap, the commit point, the value shown next and the next digit's enable.
    always_comb begin
        frame_wrap = en && (state == SHOW) && (cnt == CNT_LAST) && (idx == IDX_LAST);
        commit     = (state == OFF) || frame_wrap;
        active_nx  = (commit && pending_valid) ? pending : active;
        idx_nx     = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        show_mask  = digit_visible(active_nx, int'(idx), lzb)
                     ? (NUM_DIGITS'(1) << idx) : '0;
    end

    // Capture load requests into the pending register and acknowledge them one cycle later.
    // A load on a commit edge wins over the clear, so the new data stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending           <= '0;
            pending_valid     <= 1'b0;
            load_bus.load_ack <= 1'b0;
        end else begin
            load_bus.load_ack <= load_bus.load_req;
            if (load_bus.load_req) begin
                pending       <= load_bus.load_data;
                pending_valid <= 1'b1;
            end else if (commit) begin
                pending_valid <= 1'b0;
            end
        end
    end

    // Scan FSM: step through the blank and show phases of each digit slot and drive the registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            digit_en   <= '0;
            digit_bcd  <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            active     <= active_nx;
            frame_done <= 1'b0;
            digit_en   <= '0;
            if (!en) begin
                state     <= OFF;
                cnt       <= '0;
                idx       <= '0;
                digit_bcd <= 4'd0;
            end else begin
                case (state)
                    OFF: begin
                        state     <= BLANK;
                        cnt       <= '0;
                        idx       <= '0;
                        digit_bcd <= nibble(active_nx, 0);
                    end
                    BLANK: begin
                        cnt       <= cnt + CW'(1);
                        digit_bcd <= nibble(active_nx, int'(idx));
                        if (cnt == BLANK_LAST) begin
                            state    <= SHOW;
                            digit_en <= show_mask;
                        end
                    end
                    SHOW: begin
                        if (cnt == CNT_LAST) begin
                            state      <= BLANK;
                            cnt        <= '0;
                            idx        <= idx_nx;
                            frame_done <= frame_wrap;
                            digit_bcd  <= nibble(active_nx, int'(idx_nx));
                        end else begin
                            cnt       <= cnt + CW'(1);
                            digit_en  <= show_mask;
                            digit_bcd <= nibble(active_nx, int'(idx));
                        end
                    end
                    default: begin
                        state     <= OFF;
                        cnt       <= '0;
                        idx       <= '0;
                        digit_bcd <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
